// File: rtl/memory_cycle_lsu.sv
// Memory stage: turns loads/stores into a valid/ready data-memory transaction,
// stalls upstream while the access is outstanding, and drives the MEM/WB register.
module memory_cycle_lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RegWriteM,
    input  logic          MemWriteM,
    input  logic          ResultSrcM,
    input  logic [4:0]    RD_M,
    input  logic [31:0]   PCPlus4M,
    input  logic [31:0]   ALU_ResultM,
    input  logic [DW-1:0] WriteDataM,
    output logic          StallM,
    output logic          MisalignM,
    output logic          dmem_req_valid,
    input  logic          dmem_req_ready,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_rsp_valid,
    input  logic [DW-1:0] dmem_rdata,
    output logic          RegWriteW,
    output logic          ResultSrcW,
    output logic [4:0]    RD_W,
    output logic [31:0]   PCPlus4W,
    output logic [31:0]   ALU_ResultW,
    output logic [DW-1:0] ReadDataW
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          access;
    logic          misal;
    logic          load_done;

    logic          reg_write_q, reg_write_d;
    logic          result_src_q, result_src_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   pc_plus4_q, pc_plus4_d;
    logic [31:0]   alu_result_q, alu_result_d;
    logic [DW-1:0] read_data_q, read_data_d;

    assign access = MemWriteM | ResultSrcM;
    assign misal  = access & (ALU_ResultM[1:0] != 2'b00);

    // Address/data come straight from EX/MEM; the stall keeps them stable.
    assign dmem_we        = MemWriteM;
    assign dmem_addr      = ALU_ResultM[AW-1:0];
    assign dmem_wdata     = WriteDataM;
    assign dmem_req_valid = access & ~misal & ((state_q == IDLE) | (state_q == WAIT_ACK));
    assign MisalignM      = misal & (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        StallM    = 1'b0;
        load_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !misal) begin
                    if (!dmem_req_ready) begin
                        state_d = WAIT_ACK;
                        StallM  = 1'b1;
                    end else if (!MemWriteM) begin
                        state_d = WAIT_RSP;
                        StallM  = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                if (!dmem_req_ready) begin
                    StallM = 1'b1;
                end else if (MemWriteM) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RSP;
                    StallM  = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    state_d   = IDLE;
                    load_done = 1'b1;
                end else begin
                    StallM = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // While stalled, writeback sees a bubble; payload fields simply hold.
    always_comb begin
        reg_write_d  = RegWriteM & ~misal;
        result_src_d = ResultSrcM;
        rd_d         = RD_M;
        pc_plus4_d   = PCPlus4M;
        alu_result_d = ALU_ResultM;
        read_data_d  = load_done ? dmem_rdata : read_data_q;
        if (StallM) begin
            reg_write_d  = 1'b0;
            result_src_d = 1'b0;
            rd_d         = rd_q;
            pc_plus4_d   = pc_plus4_q;
            alu_result_d = alu_result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= 5'd0;
            pc_plus4_q   <= 32'd0;
            alu_result_q <= 32'd0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
        end
    end

    assign RegWriteW   = reg_write_q;
    assign ResultSrcW  = result_src_q;
    assign RD_W        = rd_q;
    assign PCPlus4W    = pc_plus4_q;
    assign ALU_ResultW = alu_result_q;
    assign ReadDataW   = read_data_q;

endmodule

// File: tb/tb_memory_cycle_lsu.sv
// Directed bench for memory_cycle_lsu: hand-computed expectations checked with
// immediate assertions, inputs driven 1ns after posedge, outputs sampled 2ns after.
module tb_memory_cycle_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
    logic        StallM, MisalignM;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int n_chk  = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    int hs0;

    always #5 clk = ~clk;

    memory_cycle_lsu #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM),
        .WriteDataM(WriteDataM),
        .StallM(StallM), .MisalignM(MisalignM),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
    );

    always @(posedge clk) begin
        if (!rst && dmem_req_valid && dmem_req_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        RD_M        = rd;
        PCPlus4M    = pc;
        ALU_ResultM = alu;
        WriteDataM  = wd;
    endtask

    initial begin
        rst = 1'b1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("rst_rd", {27'd0, RD_W}, 32'd0);
        chk("rst_alu", ALU_ResultW, 32'd0);
        chk("rst_rdata", ReadDataW, 32'd0);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_reqv", {31'd0, dmem_req_valid}, 32'd0);

        // ALU op with no memory access: 1-cycle pass-through
        drive(1'b1, 1'b0, 1'b0, 5'd5, 32'h40, 32'h1234, 32'd0);
        settle();
        chk("alu_stall", {31'd0, StallM}, 32'd0);
        chk("alu_reqv", {31'd0, dmem_req_valid}, 32'd0);
        tick();
        chk("alu_regwrite", {31'd0, RegWriteW}, 32'd1);
        chk("alu_rd", {27'd0, RD_W}, 32'd5);
        chk("alu_result", ALU_ResultW, 32'h1234);
        chk("alu_pc4", PCPlus4W, 32'h40);

        // Store accepted immediately
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h44, 32'h100, 32'hDEADBEEF);
        dmem_req_ready = 1'b1;
        settle();
        chk("st_reqv", {31'd0, dmem_req_valid}, 32'd1);
        chk("st_we", {31'd0, dmem_we}, 32'd1);
        chk("st_addr", dmem_addr, 32'h100);
        chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("st_stall", {31'd0, StallM}, 32'd0);
        tick();
        dmem_req_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h48, 32'h0, 32'd0);
        settle();
        chk("st_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("st_alu_w", ALU_ResultW, 32'h100);
        chk("st_idle_stall", {31'd0, StallM}, 32'd0);
        chk("st_idle_reqv", {31'd0, dmem_req_valid}, 32'd0);

        // Load from 0x200: ready low 3 cycles, response 2 cycles after acceptance
        drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h80, 32'h200, 32'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ld_wait_stall", {31'd0, StallM}, 32'd1);
            chk("ld_wait_reqv", {31'd0, dmem_req_valid}, 32'd1);
            chk("ld_wait_addr", dmem_addr, 32'h200);
            tick();
            chk("ld_bubble_rw", {31'd0, RegWriteW}, 32'd0);
            chk("ld_bubble_rs", {31'd0, ResultSrcW}, 32'd0);
        end
        dmem_req_ready = 1'b1;
        settle();
        chk("ld_acc_stall", {31'd0, StallM}, 32'd1);
        chk("ld_acc_reqv", {31'd0, dmem_req_valid}, 32'd1);
        tick();
        dmem_req_ready = 1'b0;
        settle();
        chk("ld_rsp_stall", {31'd0, StallM}, 32'd1);
        chk("ld_rsp_reqv", {31'd0, dmem_req_valid}, 32'd0);
        chk("ld_rsp_bubble", {31'd0, RegWriteW}, 32'd0);
        tick();
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hCAFEF00D;
        settle();
        chk("ld_done_stall", {31'd0, StallM}, 32'd0);
        chk("ld_done_hold", ReadDataW, 32'd0);
        tick();
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h84, 32'h0, 32'd0);
        chk("ld_rdata", ReadDataW, 32'hCAFEF00D);
        chk("ld_rs", {31'd0, ResultSrcW}, 32'd1);
        chk("ld_rw", {31'd0, RegWriteW}, 32'd1);
        chk("ld_rd", {27'd0, RD_W}, 32'd7);
        chk("ld_alu_w", ALU_ResultW, 32'h200);

        // Misaligned load to 0x202: no request even with ready high
        drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h88, 32'h202, 32'd0);
        dmem_req_ready = 1'b1;
        settle();
        chk("mis_pulse", {31'd0, MisalignM}, 32'd1);
        chk("mis_reqv", {31'd0, dmem_req_valid}, 32'd0);
        chk("mis_stall", {31'd0, StallM}, 32'd0);
        tick();
        dmem_req_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h8C, 32'h0, 32'd0);
        settle();
        chk("mis_pulse_end", {31'd0, MisalignM}, 32'd0);
        chk("mis_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("mis_alu_w", ALU_ResultW, 32'h202);
        chk("mis_rdata_hold", ReadDataW, 32'hCAFEF00D);

        // Reset while waiting for a load response; the late response is dropped
        drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h90, 32'h300, 32'd0);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        settle();
        chk("rr_stall", {31'd0, StallM}, 32'd1);
        chk("rr_reqv", {31'd0, dmem_req_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'd0);
        settle();
        chk("rr_rw", {31'd0, RegWriteW}, 32'd0);
        chk("rr_rdata", ReadDataW, 32'd0);
        chk("rr_rd", {27'd0, RD_W}, 32'd0);
        chk("rr_stall_clr", {31'd0, StallM}, 32'd0);
        chk("rr_reqv_clr", {31'd0, dmem_req_valid}, 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hBAD0BAD0;
        tick();
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'd0;
        chk("rr_late_rsp", ReadDataW, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h94, 32'h55, 32'd0);
        settle();
        chk("rr_alu_stall", {31'd0, StallM}, 32'd0);
        tick();
        chk("rr_alu_rw", {31'd0, RegWriteW}, 32'd1);
        chk("rr_alu_rd", {27'd0, RD_W}, 32'd3);
        chk("rr_alu_res", ALU_ResultW, 32'h55);

        // Back-to-back load then ALU op
        hs0 = hs_cnt;
        drive(1'b1, 1'b0, 1'b1, 5'd10, 32'hA0, 32'h400, 32'd0);
        dmem_req_ready = 1'b1;
        settle();
        chk("bb_reqv", {31'd0, dmem_req_valid}, 32'd1);
        chk("bb_stall", {31'd0, StallM}, 32'd1);
        tick();
        dmem_req_ready = 1'b0;
        settle();
        chk("bb_wait_reqv", {31'd0, dmem_req_valid}, 32'd0);
        chk("bb_wait_stall", {31'd0, StallM}, 32'd1);
        tick();
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h12345678;
        settle();
        chk("bb_done_stall", {31'd0, StallM}, 32'd0);
        chk("bb_done_reqv", {31'd0, dmem_req_valid}, 32'd0);
        tick();
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'd0;
        drive(1'b1, 1'b0, 1'b0, 5'd11, 32'hA4, 32'h77, 32'd0);
        chk("bb_ld_rd", {27'd0, RD_W}, 32'd10);
        chk("bb_ld_rdata", ReadDataW, 32'h12345678);
        chk("bb_ld_rw", {31'd0, RegWriteW}, 32'd1);
        chk("bb_ld_rs", {31'd0, ResultSrcW}, 32'd1);
        settle();
        chk("bb_alu_reqv", {31'd0, dmem_req_valid}, 32'd0);
        chk("bb_alu_stall", {31'd0, StallM}, 32'd0);
        tick();
        chk("bb_alu_rd", {27'd0, RD_W}, 32'd11);
        chk("bb_alu_res", ALU_ResultW, 32'h77);
        chk("bb_alu_rs", {31'd0, ResultSrcW}, 32'd0);
        chk("bb_alu_rdata", ReadDataW, 32'h12345678);
        chk("bb_one_req", hs_cnt - hs0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
